// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the write-back requester handshake, the decode-side scoreboard
// query and the RegisterFile write port of regfile_wb_arbiter.
//
//   req_valid/req_rd/req_data/req_ready : per-requester valid/ready write-back
//   issue_valid/issue_rd                : decode marks a destination pending
//   rs1/rs2/busy_rs1/busy_rs2           : decode hazard query
//   rf_reg_write/rf_rd/rf_write_data    : registered RegisterFile write port
//   pending                             : scoreboard vector (visibility)
//
// Modports: slave = the arbiter, master = requesters/decode/observer.
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [5*NUM_REQ-1:0]    req_rd;
    logic [XLEN*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic                    busy_rs1;
    logic                    busy_rs2;
    logic                    rf_reg_write;
    logic [4:0]              rf_rd;
    logic [XLEN-1:0]         rf_write_data;
    logic [31:0]             pending;

    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
        output req_ready, busy_rs1, busy_rs2, rf_reg_write, rf_rd,
               rf_write_data, pending
    );

    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
        input  req_ready, busy_rs1, busy_rs2, rf_reg_write, rf_rd,
               rf_write_data, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single RegisterFile write port among NUM_REQ write-back
// requesters. Arbitration is combinational round-robin starting at ptr; the
// winner is registered into the rf_* output stage (one cycle latency, one
// write per cycle). A one-bit-per-register scoreboard tracks issued but not
// yet written destinations and answers busy queries for rs1/rs2.
//
// Ports:
//   clk   - clock, all state updates on posedge
//   reset - asynchronous, active-high reset
//   bus   - regfile_wb_arbiter_if.slave (requesters, decode, RF write port)
//
// Build option:
//   WB_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins), no ptr register
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req_ready_c;
    logic               grant_valid;
    logic [4:0]         grant_rd;
    logic [XLEN-1:0]    grant_data;

    logic               rf_reg_write_q, rf_reg_write_d;
    logic [4:0]         rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]    rf_write_data_q, rf_write_data_d;
    logic [31:0]        pending_q, pending_d;

`ifndef WB_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   ptr_q, ptr_d;
`endif

    // Winner search. Round-robin walks a doubled index range so that the
    // wrap-around is expressed with constant indices only.
    always_comb begin
        req_ready_c = '0;
        grant_valid = 1'b0;
`ifdef WB_ARB_FIXED_PRIO_EN
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_valid && bus.req_valid[j]) begin
                grant_valid    = 1'b1;
                req_ready_c[j] = 1'b1;
            end
        end
`else
        for (int j = 0; j < 2 * NUM_REQ; j++) begin
            if (!grant_valid && (j >= int'(ptr_q)) && bus.req_valid[j % NUM_REQ]) begin
                grant_valid              = 1'b1;
                req_ready_c[j % NUM_REQ] = 1'b1;
            end
        end
`endif
    end

    // One-hot mux of the winning requester's payload.
    always_comb begin
        grant_rd   = '0;
        grant_data = '0;
`ifndef WB_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready_c[k]) begin
                grant_rd   = bus.req_rd[k*5 +: 5];
                grant_data = bus.req_data[k*XLEN +: XLEN];
`ifndef WB_ARB_FIXED_PRIO_EN
                ptr_d      = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
`endif
            end
        end
    end

    // Output stage: rd/data hold when idle, only reg_write drops. A grant to
    // x0 is consumed but never turned into a write.
    always_comb begin
        rf_reg_write_d  = 1'b0;
        rf_rd_d         = rf_rd_q;
        rf_write_data_d = rf_write_data_q;
        if (grant_valid) begin
            rf_rd_d         = grant_rd;
            rf_write_data_d = grant_data;
            rf_reg_write_d  = (grant_rd != 5'd0);
        end
    end

    // Scoreboard: the set is applied after the clear so a new producer
    // issued in the write-back cycle of an older one stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (rf_reg_write_q) begin
            pending_d[rf_rd_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_reg_write_q  <= 1'b0;
            rf_rd_q         <= '0;
            rf_write_data_q <= '0;
            pending_q       <= '0;
        end else begin
            rf_reg_write_q  <= rf_reg_write_d;
            rf_rd_q         <= rf_rd_d;
            rf_write_data_q <= rf_write_data_d;
            pending_q       <= pending_d;
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.req_ready     = req_ready_c;
    assign bus.rf_reg_write  = rf_reg_write_q;
    assign bus.rf_rd         = rf_rd_q;
    assign bus.rf_write_data = rf_write_data_q;
    assign bus.pending       = pending_q;
    // pending_q[0] is never set, so x0 always reads not-busy.
    assign bus.busy_rs1      = pending_q[bus.rs1];
    assign bus.busy_rs2      = pending_q[bus.rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter (NUM_REQ=3, XLEN=32) with a small
// RegisterFile model fed by the rf_* port. Expected values are hand-derived;
// define WB_ARB_FIXED_PRIO_EN for both DUT and bench to select the
// fixed-priority expectations.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [XLEN-1:0] rf_mem [32] = '{default: '0};

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RegisterFile model: commits at the end of the cycle rf_reg_write is high.
    always @(posedge clk) begin
        if (bus.rf_reg_write && bus.rf_rd != 5'd0) begin
            rf_mem[bus.rf_rd] <= bus.rf_write_data;
        end
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    localparam logic [2:0]  RR_READY [3] = '{3'b001, 3'b001, 3'b001};
    localparam logic [4:0]  RR_RD    [3] = '{5'd5, 5'd5, 5'd5};
    localparam logic [31:0] RR_DATA  [3] = '{32'd100, 32'd100, 32'd100};
    localparam logic [31:0] EXP_X6 = 32'd0;
    localparam logic [31:0] EXP_X7 = 32'd0;
    localparam logic [2:0]  PTR2_READY = 3'b001;
`else
    localparam logic [2:0]  RR_READY [3] = '{3'b001, 3'b010, 3'b100};
    localparam logic [4:0]  RR_RD    [3] = '{5'd5, 5'd6, 5'd7};
    localparam logic [31:0] RR_DATA  [3] = '{32'd100, 32'd200, 32'd300};
    localparam logic [31:0] EXP_X6 = 32'd200;
    localparam logic [31:0] EXP_X7 = 32'd300;
    localparam logic [2:0]  PTR2_READY = 3'b100;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                           input logic [31:0] d);
        bus.req_valid[i]          = v;
        bus.req_rd[i*5 +: 5]      = rd;
        bus.req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 5'd5, 32'd100);
        set_req(1, 1'b1, 5'd6, 32'd200);
        set_req(2, 1'b1, 5'd7, 32'd300);
        tick();
        tick();
        vectors++;
        if (bus.rf_reg_write !== 1'b0) begin
            $display("FAIL rst_reg_write got=%b exp=0", bus.rf_reg_write);
            miscompares++;
        end
        vectors++;
        if (bus.pending !== 32'd0) begin
            $display("FAIL rst_pending got=%h exp=0", bus.pending);
            miscompares++;
        end
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            $display("FAIL rst_ready got=%b exp=001", bus.req_ready);
            miscompares++;
        end
        vectors++;
        if (bus.rf_rd !== 5'd0 || bus.rf_write_data !== 32'd0) begin
            $display("FAIL rst_rf_out got=%0d/%0d exp=0/0", bus.rf_rd, bus.rf_write_data);
            miscompares++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            $display("FAIL rst_first_grant got=%b exp=001", bus.req_ready);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.req_ready !== RR_READY[c]) begin
                $display("FAIL rr_ready[%0d] got=%b exp=%b", c, bus.req_ready, RR_READY[c]);
                miscompares++;
            end
            tick();
            vectors++;
            if (bus.rf_reg_write !== 1'b1 || bus.rf_rd !== RR_RD[c] ||
                bus.rf_write_data !== RR_DATA[c]) begin
                $display("FAIL rr_rf[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", c,
                         bus.rf_reg_write, bus.rf_rd, bus.rf_write_data, RR_RD[c], RR_DATA[c]);
                miscompares++;
            end
        end
        bus.req_valid = 3'b000;
        tick();
        vectors++;
        if (bus.rf_reg_write !== 1'b0 || bus.rf_rd !== RR_RD[2]) begin
            $display("FAIL rr_idle got=%b/%0d exp=0/%0d", bus.rf_reg_write, bus.rf_rd, RR_RD[2]);
            miscompares++;
        end
        vectors++;
        if (rf_mem[5] !== 32'd100 || rf_mem[6] !== EXP_X6 || rf_mem[7] !== EXP_X7) begin
            $display("FAIL rr_rf_readback got=%0d/%0d/%0d exp=100/%0d/%0d",
                     rf_mem[5], rf_mem[6], rf_mem[7], EXP_X6, EXP_X7);
            miscompares++;
        end
    endtask

    task automatic test_x0_write();
        set_req(1, 1'b1, 5'd0, 32'd999);
        #1;
        vectors++;
        if (bus.req_ready !== 3'b010) begin
            $display("FAIL x0_ready got=%b exp=010", bus.req_ready);
            miscompares++;
        end
        tick();
        bus.req_valid = 3'b000;
        vectors++;
        if (bus.rf_reg_write !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_write_data !== 32'd999) begin
            $display("FAIL x0_rf got=%b/%0d/%0d exp=0/0/999",
                     bus.rf_reg_write, bus.rf_rd, bus.rf_write_data);
            miscompares++;
        end
        bus.req_valid = 3'b111;
        #1;
        vectors++;
        if (bus.req_ready !== PTR2_READY) begin
            $display("FAIL x0_ptr_adv got=%b exp=%b", bus.req_ready, PTR2_READY);
            miscompares++;
        end
        bus.req_valid = 3'b000;
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd10;
        bus.rs1         = 5'd10;
        #1;
        vectors++;
        if (bus.busy_rs1 !== 1'b0) begin
            $display("FAIL sb_pre_issue got=%b exp=0", bus.busy_rs1);
            miscompares++;
        end
        tick();
        bus.issue_valid = 1'b0;
        vectors++;
        if (bus.busy_rs1 !== 1'b1 || bus.pending !== 32'h0000_0400) begin
            $display("FAIL sb_issue got=%b/%h exp=1/00000400", bus.busy_rs1, bus.pending);
            miscompares++;
        end
        set_req(2, 1'b1, 5'd10, 32'd75);
        #1;
        vectors++;
        if (bus.req_ready !== 3'b100) begin
            $display("FAIL sb_ready got=%b exp=100", bus.req_ready);
            miscompares++;
        end
        tick();
        bus.req_valid = 3'b000;
        vectors++;
        if (bus.rf_reg_write !== 1'b1 || bus.busy_rs1 !== 1'b1) begin
            $display("FAIL sb_wb_cycle got=%b/%b exp=1/1", bus.rf_reg_write, bus.busy_rs1);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.busy_rs1 !== 1'b0 || bus.pending !== 32'd0) begin
            $display("FAIL sb_clear got=%b/%h exp=0/0", bus.busy_rs1, bus.pending);
            miscompares++;
        end
        vectors++;
        if (rf_mem[10] !== 32'd75) begin
            $display("FAIL sb_rf_x10 got=%0d exp=75", rf_mem[10]);
            miscompares++;
        end
    endtask

    task automatic test_same_cycle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        set_req(0, 1'b1, 5'd3, 32'd33);
        tick();
        bus.req_valid = 3'b000;
        vectors++;
        if (bus.rf_reg_write !== 1'b1 || bus.rf_rd !== 5'd3 || bus.pending !== 32'h8) begin
            $display("FAIL sc_setup got=%b/%0d/%h exp=1/3/00000008",
                     bus.rf_reg_write, bus.rf_rd, bus.pending);
            miscompares++;
        end
        tick();
        bus.rs2 = 5'd3;
        #1;
        vectors++;
        if (bus.pending !== 32'h8 || bus.busy_rs2 !== 1'b1) begin
            $display("FAIL sc_set_wins got=%h/%b exp=00000008/1", bus.pending, bus.busy_rs2);
            miscompares++;
        end
        bus.issue_rd = 5'd0;
        bus.rs1      = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        vectors++;
        if (bus.pending !== 32'h8 || bus.busy_rs1 !== 1'b0) begin
            $display("FAIL sc_issue_x0 got=%h/%b exp=00000008/0", bus.pending, bus.busy_rs1);
            miscompares++;
        end
        set_req(1, 1'b1, 5'd3, 32'd34);
        #1;
        vectors++;
        if (bus.req_ready !== 3'b010) begin
            $display("FAIL sc_ready got=%b exp=010", bus.req_ready);
            miscompares++;
        end
        tick();
        bus.req_valid = 3'b000;
        tick();
        vectors++;
        if (bus.pending !== 32'd0 || rf_mem[3] !== 32'd34) begin
            $display("FAIL sc_drain got=%h/%0d exp=0/34", bus.pending, rf_mem[3]);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        set_req(0, 1'b1, 5'd4, 32'd50);
        #1;
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            $display("FAIL rm_ready got=%b exp=001", bus.req_ready);
            miscompares++;
        end
        tick();
        bus.issue_valid = 1'b0;
        bus.req_valid   = 3'b000;
        vectors++;
        if (bus.rf_reg_write !== 1'b1 || bus.rf_rd !== 5'd4 || bus.pending !== 32'h200) begin
            $display("FAIL rm_inflight got=%b/%0d/%h exp=1/4/00000200",
                     bus.rf_reg_write, bus.rf_rd, bus.pending);
            miscompares++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.rf_reg_write !== 1'b0 || bus.pending !== 32'd0 ||
            bus.rf_rd !== 5'd0 || bus.rf_write_data !== 32'd0) begin
            $display("FAIL rm_async_clear got=%b/%h/%0d/%0d exp=0/0/0/0",
                     bus.rf_reg_write, bus.pending, bus.rf_rd, bus.rf_write_data);
            miscompares++;
        end
        tick();
        vectors++;
        if (rf_mem[4] !== 32'd0) begin
            $display("FAIL rm_x4_dropped got=%0d exp=0", rf_mem[4]);
            miscompares++;
        end
        reset = 1'b0;
        bus.req_valid = 3'b111;
        #1;
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            $display("FAIL rm_ptr_reset got=%b exp=001", bus.req_ready);
            miscompares++;
        end
        bus.req_valid = 3'b000;
        tick();
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_rd      = '0;
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        test_reset();
        test_round_robin();
        test_x0_write();
        test_scoreboard();
        test_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
